// File: rtl/minibus_arbiter.sv
// minibus_arbiter
//   Shares one minibus slave-side port between NUM_MASTERS requesters using
//   round-robin arbitration. A grant is held for a whole transaction, until the
//   slave answers with ack or err. A watchdog aborts a transaction that sees no
//   answer for TIMEOUT_CYCLES BUSY cycles and reports err to the owner.
//
// Ports
//   CLK, nRST              clock (rising edge), asynchronous active-low reset
//   master_req_*           per-master request fields, master i in slice i
//                          (addr, wdata, width, ren, wen)
//   master_res_*           per-master response fields (rdata, ack, err)
//   slave_req_*            request forwarded to the decoder/slave
//   slave_res_*            response from the decoder/slave
//   grant                  one-hot current owner, all zero in IDLE
//   busy                   high while a transaction is in progress
module minibus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic [NUM_MASTERS*ADDR_W-1:0] master_req_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] master_req_wdata,
    input  logic [NUM_MASTERS*2-1:0]      master_req_width,
    input  logic [NUM_MASTERS-1:0]        master_req_ren,
    input  logic [NUM_MASTERS-1:0]        master_req_wen,
    output logic [NUM_MASTERS*DATA_W-1:0] master_res_rdata,
    output logic [NUM_MASTERS-1:0]        master_res_ack,
    output logic [NUM_MASTERS-1:0]        master_res_err,
    output logic [ADDR_W-1:0]             slave_req_addr,
    output logic [DATA_W-1:0]             slave_req_wdata,
    output logic [1:0]                    slave_req_width,
    output logic                          slave_req_ren,
    output logic                          slave_req_wen,
    input  logic [DATA_W-1:0]             slave_res_rdata,
    input  logic                          slave_res_ack,
    input  logic                          slave_res_err,
    output logic [NUM_MASTERS-1:0]        grant,
    output logic                          busy
);

    localparam int OWN_W = $clog2(NUM_MASTERS);
    // A disabled timeout still needs a legal (1-bit) counter width.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [OWN_W-1:0] OWN_LAST = OWN_W'(NUM_MASTERS - 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic                   busy_q, busy_d;
    logic [OWN_W-1:0]       owner_q, owner_d;
    logic [OWN_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [NUM_MASTERS-1:0] req_vec;
    logic [OWN_W-1:0]       win_idx;
    logic [OWN_W-1:0]       scan_idx;
    logic                   any_req;
    logic                   owner_req;
    logic                   slave_resp;
    logic                   timeout_hit;

    assign req_vec    = master_req_ren | master_req_wen;
    assign any_req    = |req_vec;
    assign owner_req  = req_vec[owner_q];
    assign slave_resp = slave_res_ack | slave_res_err;
    // A slave answer in the same cycle always beats the watchdog.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == BUSY) &&
                         (cnt_q == CNT_LAST) && !slave_resp;

    assign grant = grant_q;
    assign busy  = busy_q;

    // Round-robin search from rr_ptr upward. Scanning from the farthest
    // candidate back towards rr_ptr lets the closest requester overwrite last.
    always_comb begin
        win_idx  = rr_ptr_q;
        scan_idx = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            scan_idx = OWN_W'((int'(rr_ptr_q) + k) % NUM_MASTERS);
            if (req_vec[scan_idx]) begin
                win_idx = scan_idx;
            end
        end
    end

    // Combinational forwarding between the owner and the slave.
    always_comb begin
        slave_req_addr   = '0;
        slave_req_wdata  = '0;
        slave_req_width  = '0;
        slave_req_ren    = 1'b0;
        slave_req_wen    = 1'b0;
        master_res_rdata = '0;
        master_res_ack   = '0;
        master_res_err   = '0;
        // An owner that dropped ren/wen has abandoned the transfer: nothing
        // goes to the slave and no response is returned.
        if (state_q == BUSY && owner_req) begin
            if (!timeout_hit) begin
                slave_req_addr  = master_req_addr[owner_q*ADDR_W +: ADDR_W];
                slave_req_wdata = master_req_wdata[owner_q*DATA_W +: DATA_W];
                slave_req_width = master_req_width[owner_q*2 +: 2];
                slave_req_ren   = master_req_ren[owner_q];
                slave_req_wen   = master_req_wen[owner_q];
            end
            if (slave_resp) begin
                master_res_rdata[owner_q*DATA_W +: DATA_W] = slave_res_rdata;
                master_res_ack[owner_q] = slave_res_ack;
                master_res_err[owner_q] = slave_res_err;
            end else if (timeout_hit) begin
                master_res_err[owner_q] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = BUSY;
                    owner_d = win_idx;
                    cnt_d   = '0;
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        grant_d[i] = (win_idx == OWN_W'(i));
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (!owner_req) begin
                    // Abort keeps rr_ptr so the same master retains priority.
                    state_d = IDLE;
                    grant_d = '0;
                end else if (slave_resp || timeout_hit) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = (owner_q == OWN_LAST) ? '0 : owner_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d == BUSY);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_minibus_arbiter.sv
module tb_minibus_arbiter;

    localparam int NM = 2;
    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [63:0] m_addr = '0;
    logic [63:0] m_wdata = '0;
    logic [3:0]  m_width = '0;
    logic [1:0]  m_ren = '0;
    logic [1:0]  m_wen = '0;
    logic [63:0] r_rdata;
    logic [1:0]  r_ack, r_err;
    logic [31:0] s_addr, s_wdata;
    logic [1:0]  s_width;
    logic        s_ren, s_wen;
    logic [31:0] sl_rdata;
    logic        sl_ack, sl_err;
    logic [1:0]  grant;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    minibus_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .nRST(nRST),
        .master_req_addr(m_addr), .master_req_wdata(m_wdata),
        .master_req_width(m_width), .master_req_ren(m_ren), .master_req_wen(m_wen),
        .master_res_rdata(r_rdata), .master_res_ack(r_ack), .master_res_err(r_err),
        .slave_req_addr(s_addr), .slave_req_wdata(s_wdata), .slave_req_width(s_width),
        .slave_req_ren(s_ren), .slave_req_wen(s_wen),
        .slave_res_rdata(sl_rdata), .slave_res_ack(sl_ack), .slave_res_err(sl_err),
        .grant(grant), .busy(busy)
    );

    // Bench slave: answers slv_lat cycles after first seeing a request.
    // mode 0 = never answers, 1 = ack, 2 = err.
    int          slv_mode = 0;
    int          slv_lat = 1;
    logic [31:0] slv_rdata = '0;
    int          slv_cnt;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) slv_cnt <= 0;
        else if ((s_ren | s_wen) && !(sl_ack | sl_err)) slv_cnt <= slv_cnt + 1;
        else slv_cnt <= 0;
    end
    assign sl_ack   = (slv_mode == 1) && (slv_cnt == slv_lat);
    assign sl_err   = (slv_mode == 2) && (slv_cnt == slv_lat);
    assign sl_rdata = sl_ack ? slv_rdata : 32'h0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: who owns the bus, whose turn it is, and how many
    // BUSY cycles the current transaction has lasted (1-based).
    int m_owner = -1;
    int m_rr = 0;
    int m_bcyc = 0;
    int m_nxt;
    int m_pick;
    logic m_oreq, m_resp, m_to;
    logic [1:0]  e_grant, e_ack, e_err;
    logic        e_busy, e_sren, e_swen;
    logic [31:0] e_saddr, e_swdata;
    logic [1:0]  e_swidth;
    logic [63:0] e_rdata;

    always @(negedge CLK) begin
        e_grant = '0; e_busy = 1'b0; e_saddr = '0; e_swdata = '0; e_swidth = '0;
        e_sren = 1'b0; e_swen = 1'b0; e_rdata = '0; e_ack = '0; e_err = '0;
        m_oreq = 1'b0; m_resp = 1'b0; m_to = 1'b0;
        if (!nRST) begin
            m_owner = -1; m_rr = 0; m_bcyc = 0;
        end else if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_busy = 1'b1;
            m_oreq = m_ren[m_owner] | m_wen[m_owner];
            m_resp = sl_ack | sl_err;
            m_to   = !m_resp && (m_bcyc == TO);
            if (m_oreq && !m_to) begin
                e_saddr  = m_addr[m_owner*32 +: 32];
                e_swdata = m_wdata[m_owner*32 +: 32];
                e_swidth = m_width[m_owner*2 +: 2];
                e_sren   = m_ren[m_owner];
                e_swen   = m_wen[m_owner];
            end
            if (m_oreq && m_resp) begin
                e_rdata[m_owner*32 +: 32] = sl_rdata;
                e_ack[m_owner] = sl_ack;
                e_err[m_owner] = sl_err;
            end else if (m_oreq && m_to) begin
                e_err[m_owner] = 1'b1;
            end
        end
        chk("grant", {62'b0, grant}, {62'b0, e_grant});
        chk("busy", {63'b0, busy}, {63'b0, e_busy});
        chk("slave_addr", {32'b0, s_addr}, {32'b0, e_saddr});
        chk("slave_wdata", {32'b0, s_wdata}, {32'b0, e_swdata});
        chk("slave_width", {62'b0, s_width}, {62'b0, e_swidth});
        chk("slave_ren_wen", {62'b0, s_ren, s_wen}, {62'b0, e_sren, e_swen});
        chk("res_rdata", r_rdata, e_rdata);
        chk("res_ack", {62'b0, r_ack}, {62'b0, e_ack});
        chk("res_err", {62'b0, r_err}, {62'b0, e_err});
        if (nRST) begin
            if (m_owner < 0) begin
                m_nxt = -1;
                for (int k = 0; k < NM; k++) begin
                    m_pick = (m_rr + k) % NM;
                    if (m_nxt < 0 && (m_ren[m_pick] | m_wen[m_pick])) m_nxt = m_pick;
                end
                if (m_nxt >= 0) begin
                    m_owner = m_nxt;
                    m_bcyc = 1;
                end
            end else if (!m_oreq) begin
                m_owner = -1;
            end else if (m_resp || m_to) begin
                m_rr = (m_owner + 1) % NM;
                m_owner = -1;
            end else begin
                m_bcyc++;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        #2;
    endtask

    task automatic set_m(input int i, input logic ren, input logic wen,
                         input logic [31:0] a, input logic [31:0] d);
        m_ren[i] = ren;
        m_wen[i] = wen;
        m_addr[i*32 +: 32] = a;
        m_wdata[i*32 +: 32] = d;
        m_width[i*2 +: 2] = 2'b10;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        m_ren = '0; m_wen = '0; m_addr = '0; m_wdata = '0; m_width = '0;
        slv_mode = 0; slv_lat = 1; slv_rdata = '0;
        tick();
        chk("rst_grant", {62'b0, grant}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_slave", {s_addr, 30'b0, s_ren, s_wen}, 64'd0);
        chk("rst_res", {r_rdata[31:0], 28'b0, r_ack, r_err}, 64'd0);
        tick();
        nRST = 1'b1;
    endtask

    initial begin
        // 1: single master read, slave acks two cycles after the request
        do_reset();
        slv_mode = 1; slv_lat = 2; slv_rdata = 32'hDEAD_BEEF;
        tick(); set_m(0, 1, 0, 32'h0000_1000, 32'h0);
        mid();  chk("t1_idle_grant", {62'b0, grant}, 64'd0);
        tick(); mid(); chk("t1_grant", {62'b0, grant}, 64'd1);
        chk("t1_fwd_addr", {32'b0, s_addr}, 64'h1000);
        tick();
        tick(); mid();
        chk("t1_rdata", r_rdata, 64'h0000_0000_DEAD_BEEF);
        chk("t1_ack", {62'b0, r_ack}, 64'd1);
        tick(); set_m(0, 0, 0, 32'h0000_1000, 32'h0);
        mid();  chk("t1_back_idle", {63'b0, busy}, 64'd0);

        // 2: both masters write continuously, grants alternate
        do_reset();
        slv_mode = 1; slv_lat = 1;
        tick();
        set_m(0, 0, 1, 32'h0000_2000, 32'h1111_0000);
        set_m(1, 0, 1, 32'h0000_3000, 32'h2222_0001);
        for (int t = 0; t < 4; t++) begin
            tick(); mid();
            chk("t2_grant", {62'b0, grant}, (t % 2 == 0) ? 64'd1 : 64'd2);
            chk("t2_addr", {32'b0, s_addr}, (t % 2 == 0) ? 64'h2000 : 64'h3000);
            chk("t2_wdata", {32'b0, s_wdata}, (t % 2 == 0) ? 64'h1111_0000 : 64'h2222_0001);
            tick(); mid();
            chk("t2_ack", {62'b0, r_ack}, (t % 2 == 0) ? 64'd1 : 64'd2);
            tick();
            if (t == 3) begin
                set_m(0, 0, 0, 32'h0, 32'h0);
                set_m(1, 0, 0, 32'h0, 32'h0);
            end
            mid(); chk("t2_idle", {63'b0, busy}, 64'd0);
        end

        // 3: slave never answers M1, watchdog fires in the 4th BUSY cycle
        do_reset();
        slv_mode = 0;
        tick(); set_m(1, 1, 0, 32'h0000_4000, 32'h0);
        tick(); mid(); chk("t3_grant", {62'b0, grant}, 64'd2);
        tick(); set_m(0, 1, 0, 32'h0000_0040, 32'h0);
        mid();  chk("t3_no_err_yet", {62'b0, r_err}, 64'd0);
        tick();
        tick(); mid();
        chk("t3_err", {62'b0, r_err}, 64'd2);
        chk("t3_ack", {62'b0, r_ack}, 64'd0);
        chk("t3_slave_off", {62'b0, s_ren, s_wen}, 64'd0);
        tick(); set_m(1, 0, 0, 32'h0000_4000, 32'h0);
        slv_mode = 1; slv_lat = 1;
        mid();  chk("t3_idle", {63'b0, busy}, 64'd0);
        tick(); mid(); chk("t3_m0_grant", {62'b0, grant}, 64'd1);
        tick();
        tick(); set_m(0, 0, 0, 32'h0, 32'h0);

        // 4: slave err for M0, M1 takes the next turn
        do_reset();
        slv_mode = 2; slv_lat = 1;
        tick();
        set_m(0, 1, 0, 32'hF000_0000, 32'h0);
        set_m(1, 1, 0, 32'h0000_0080, 32'h0);
        tick(); mid(); chk("t4_grant0", {62'b0, grant}, 64'd1);
        tick(); mid();
        chk("t4_err", {62'b0, r_err}, 64'd1);
        chk("t4_ack", {62'b0, r_ack}, 64'd0);
        tick();
        tick(); mid(); chk("t4_grant1", {62'b0, grant}, 64'd2);
        tick();
        tick(); set_m(0, 0, 0, 32'h0, 32'h0); set_m(1, 0, 0, 32'h0, 32'h0);

        // 5: M0 aborts, keeps priority over M1
        do_reset();
        slv_mode = 0;
        tick();
        set_m(0, 1, 0, 32'h0000_5000, 32'h0);
        set_m(1, 1, 0, 32'h0000_6000, 32'h0);
        tick(); mid(); chk("t5_grant", {62'b0, grant}, 64'd1);
        tick(); set_m(0, 0, 0, 32'h0000_5000, 32'h0);
        mid();
        chk("t5_slave_off", {s_addr, 30'b0, s_ren, s_wen}, 64'd0);
        chk("t5_no_resp", {62'b0, r_ack | r_err}, 64'd0);
        tick(); set_m(0, 1, 0, 32'h0000_5000, 32'h0);
        slv_mode = 1; slv_lat = 1;
        mid();  chk("t5_idle", {63'b0, busy}, 64'd0);
        tick(); mid(); chk("t5_m0_again", {62'b0, grant}, 64'd1);
        tick(); mid(); chk("t5_ack", {62'b0, r_ack}, 64'd1);
        tick(); set_m(0, 0, 0, 32'h0, 32'h0); set_m(1, 0, 0, 32'h0, 32'h0);

        // 6: asynchronous reset in the middle of M1's transaction
        do_reset();
        slv_mode = 1; slv_lat = 1;
        tick(); set_m(0, 1, 0, 32'h0000_7000, 32'h0);
        tick();
        tick();
        tick(); set_m(0, 0, 0, 32'h0, 32'h0); set_m(1, 1, 0, 32'h0000_8000, 32'h0);
        slv_mode = 0;
        tick(); mid(); chk("t6_grant1", {62'b0, grant}, 64'd2);
        tick(); mid();
        nRST = 1'b0;
        #1;
        chk("t6_rst_grant", {62'b0, grant}, 64'd0);
        chk("t6_rst_busy", {63'b0, busy}, 64'd0);
        chk("t6_rst_slave", {s_addr, 30'b0, s_ren, s_wen}, 64'd0);
        tick();
        nRST = 1'b1;
        set_m(0, 1, 0, 32'h0000_7000, 32'h0);
        slv_mode = 1; slv_lat = 1;
        mid();  chk("t6_idle", {63'b0, busy}, 64'd0);
        tick(); mid(); chk("t6_rr_from_0", {62'b0, grant}, 64'd1);
        tick(); mid(); chk("t6_ack", {62'b0, r_ack}, 64'd1);
        tick(); set_m(0, 0, 0, 32'h0, 32'h0); set_m(1, 0, 0, 32'h0, 32'h0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
